// File: rtl/unsigned_multiply_if.sv
// Handshake and data bundle between the datapath sequencer and the shift-and-add multiplier.
// Signal names match the divider's handshake, so one sequencer can drive both units.
interface unsigned_multiply_if #(
    parameter int WIDTH = 32
);
    logic                 i_start;
    logic [WIDTH-1:0]     i_multiplicand;
    logic [WIDTH-1:0]     i_multiplier;
    logic                 o_ready;
    logic                 o_valid;
    logic [2*WIDTH-1:0]   o_product;

    modport master (
        output i_start,
        output i_multiplicand,
        output i_multiplier,
        input  o_ready,
        input  o_valid,
        input  o_product
    );

    modport slave (
        input  i_start,
        input  i_multiplicand,
        input  i_multiplier,
        output o_ready,
        output o_valid,
        output o_product
    );
endinterface

// File: rtl/unsigned_multiply.sv
// Sequential radix-2 shift-and-add unsigned multiplier.
// Takes a fixed WIDTH cycles per product; one operation in flight at a time.
module unsigned_multiply #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    unsigned_multiply_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q,   state_d;
    logic [PW-1:0]    addend_q,  addend_d;
    logic [PW-1:0]    acc_q,     acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] mult_q,    mult_d;
    logic [CW-1:0]    step_q,    step_d;
    logic             valid_q,   valid_d;
    logic [PW-1:0]    acc_sum;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        addend_d  = addend_q;
        acc_d     = acc_q;
        product_d = product_q;
        mult_d    = mult_q;
        step_d    = step_q;
        valid_d   = 1'b0;
        acc_sum   = acc_q + (mult_q[0] ? addend_q : '0);

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    addend_d = PW'(bus.i_multiplicand);
                    mult_d   = bus.i_multiplier;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d    = acc_sum;
                addend_d = addend_q << 1;
                mult_d   = mult_q >> 1;
                step_d   = step_q + CW'(1);
                // Final iteration: publish the sum directly so the result lands on edge E_WIDTH.
                if (step_q == STEP_LAST) begin
                    product_d = acc_sum;
                    valid_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            addend_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            mult_q    <= '0;
            step_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addend_q  <= addend_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            mult_q    <= mult_d;
            step_q    <= step_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.o_ready   = (state_q == ST_IDLE);
    assign bus.o_valid   = valid_q;
    assign bus.o_product = product_q;
endmodule

// File: tb/tb_unsigned_multiply.sv
// Self-checking bench for unsigned_multiply at WIDTH=8 and WIDTH=32.
// Expected products come from plain integer multiplication; latency is counted in edges.
module tb_unsigned_multiply;
    logic clk;
    logic rst_n;

    unsigned_multiply_if #(.WIDTH(8))  if8  ();
    unsigned_multiply_if #(.WIDTH(32)) if32 ();

    unsigned_multiply #(.WIDTH(8)) dut8 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (if8.slave)
    );

    unsigned_multiply #(.WIDTH(32)) dut32 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (if32.slave)
    );

    int vectors;
    int miscompares;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec8_t;

    vec8_t tbl [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one 8-bit operation. With now=1 the start is driven in the current (negedge) slot.
    // Leaves the caller at the negedge sample where o_valid was seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit now,
                        output logic [15:0] p, output int lat, output bit early);
        logic [15:0] prev;
        if (!now) @(negedge clk);
        check("ready_before_start8", if8.o_ready, 1'b1);
        prev              = if8.o_product;
        if8.i_start        = 1'b1;
        if8.i_multiplicand = a;
        if8.i_multiplier   = b;
        @(posedge clk);
        @(negedge clk);
        if8.i_start        = 1'b0;
        if8.i_multiplicand = 8'($urandom);
        if8.i_multiplier   = 8'($urandom);
        check("ready_drop8", if8.o_ready, 1'b0);
        check("valid_pulse8", if8.o_valid, 1'b0);
        lat   = 0;
        early = 1'b0;
        p     = if8.o_product;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if8.o_valid) begin
                lat = k;
                p   = if8.o_product;
                break;
            end
            if (if8.o_product !== prev) early = 1'b1;
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output int lat, output bit early);
        logic [63:0] prev;
        @(negedge clk);
        check("ready_before_start32", if32.o_ready, 1'b1);
        prev                = if32.o_product;
        if32.i_start        = 1'b1;
        if32.i_multiplicand = a;
        if32.i_multiplier   = b;
        @(posedge clk);
        @(negedge clk);
        if32.i_start        = 1'b0;
        if32.i_multiplicand = $urandom;
        if32.i_multiplier   = $urandom;
        check("ready_drop32", if32.o_ready, 1'b0);
        check("valid_pulse32", if32.o_valid, 1'b0);
        lat   = 0;
        early = 1'b0;
        p     = if32.o_product;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if32.o_valid) begin
                lat = k;
                p   = if32.o_product;
                break;
            end
            if (if32.o_product !== prev) early = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] p8;
        logic [63:0] p32;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [31:0] wa;
        logic [31:0] wb;
        logic [15:0] vp;
        int          lat;
        int          pulses;
        int          vedge;
        bit          early;

        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{a: 8'd3,   b: 8'd5,    p: 16'd15};
        tbl[1] = '{a: 8'd255, b: 8'd255,  p: 16'hFE01};
        tbl[2] = '{a: 8'd0,   b: 8'd200,  p: 16'd0};
        tbl[3] = '{a: 8'd200, b: 8'd0,    p: 16'd0};
        tbl[4] = '{a: 8'd1,   b: 8'hAB,   p: 16'h00AB};
        tbl[5] = '{a: 8'd128, b: 8'd2,    p: 16'd256};
        tbl[6] = '{a: 8'd17,  b: 8'd15,   p: 16'd255};
        tbl[7] = '{a: 8'hAA,  b: 8'h55,   p: 16'h3872};

        rst_n               = 1'b0;
        if8.i_start         = 1'b0;
        if8.i_multiplicand  = '0;
        if8.i_multiplier    = '0;
        if32.i_start        = 1'b0;
        if32.i_multiplicand = '0;
        if32.i_multiplier   = '0;

        #12;
        check("reset_ready8",    if8.o_ready,    1'b1);
        check("reset_valid8",    if8.o_valid,    1'b0);
        check("reset_product8",  if8.o_product,  16'd0);
        check("reset_ready32",   if32.o_ready,   1'b1);
        check("reset_valid32",   if32.o_valid,   1'b0);
        check("reset_product32", if32.o_product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table at WIDTH=8.
        for (int i = 0; i < 8; i++) begin
            run8(tbl[i].a, tbl[i].b, 1'b0, p8, lat, early);
            check($sformatf("tbl%0d_product", i), p8, tbl[i].p);
            check($sformatf("tbl%0d_latency", i), lat, 8);
            check($sformatf("tbl%0d_ready_at_valid", i), if8.o_ready, 1'b1);
            check($sformatf("tbl%0d_no_early_update", i), early, 1'b0);
        end

        // Randomized operands at WIDTH=8 against plain multiplication.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, 1'b0, p8, lat, early);
            check($sformatf("rand8_%0d_product", i), p8, 16'(ra) * 16'(rb));
            check($sformatf("rand8_%0d_latency", i), lat, 8);
        end

        // Starts while busy are ignored: one pulse, original operands.
        @(negedge clk);
        if8.i_start        = 1'b1;
        if8.i_multiplicand = 8'd7;
        if8.i_multiplier   = 8'd9;
        @(posedge clk);
        @(negedge clk);
        if8.i_start = 1'b0;
        pulses = 0;
        vedge  = 0;
        vp     = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2 || k == 5) begin
                if8.i_start        = 1'b1;
                if8.i_multiplicand = 8'd100;
                if8.i_multiplier   = 8'd100;
            end else begin
                if8.i_start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (if8.o_valid) begin
                pulses++;
                vedge = k;
                vp    = if8.o_product;
            end
        end
        if8.i_start = 1'b0;
        check("ignored_start_pulses",  pulses, 1);
        check("ignored_start_edge",    vedge,  8);
        check("ignored_start_product", vp,     16'd63);

        // Back-to-back: second start issued in the o_valid cycle of the first.
        run8(8'd12, 8'd12, 1'b0, p8, lat, early);
        check("b2b_first_product", p8,  16'd144);
        check("b2b_first_latency", lat, 8);
        run8(8'd10, 8'd11, 1'b1, p8, lat, early);
        check("b2b_second_product", p8,    16'd110);
        check("b2b_second_latency", lat,   8);
        check("b2b_product_held",   early, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        if8.i_start        = 1'b1;
        if8.i_multiplicand = 8'd9;
        if8.i_multiplier   = 8'd9;
        @(posedge clk);
        @(negedge clk);
        if8.i_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_ready",   if8.o_ready,   1'b1);
        check("midreset_valid",   if8.o_valid,   1'b0);
        check("midreset_product", if8.o_product, 16'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if8.o_valid) pulses++;
        end
        check("midreset_no_valid", pulses, 0);
        run8(8'd2, 8'd3, 1'b0, p8, lat, early);
        check("after_reset_product", p8,  16'd6);
        check("after_reset_latency", lat, 8);

        // WIDTH=32: extreme operands, then randomized.
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, p32, lat, early);
        check("max32_product", p32, 64'hFFFF_FFFE_0000_0001);
        check("max32_latency", lat, 32);
        check("max32_ready_at_valid", if32.o_ready, 1'b1);
        for (int i = 0; i < 12; i++) begin
            wa = $urandom;
            wb = $urandom;
            run32(wa, wb, p32, lat, early);
            check($sformatf("rand32_%0d_product", i), p32, 64'(wa) * 64'(wb));
            check($sformatf("rand32_%0d_latency", i), lat, 32);
            check($sformatf("rand32_%0d_no_early_update", i), early, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/unsigned_multiply.md
Name: unsigned_multiply

Overview:
- Sequential radix-2 shift-and-add unsigned multiplier; the inverse-operation companion to the team's sequential unsigned divider.
- Uses the same start/ready/valid handshake as the divider, so the GPU datapath sequencer drives both with identical control logic.
- Produces a full 2*WIDTH-bit product after a fixed WIDTH-cycle latency.
- One operation in flight at a time; no pipelining.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64. Product width is 2*WIDTH.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_reset_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  high for one tick to request a multiply; honoured only while o_ready is high.
- i_multiplicand  input  WIDTH  sampled on the edge where i_start is accepted.
- i_multiplier  input  WIDTH  sampled on the edge where i_start is accepted.
- o_ready  output  1  high when a new multiply can be accepted.
- o_valid  output  1  high for exactly one tick when the product is complete.
- o_product  output  2*WIDTH  result; valid while o_valid is high, held until the next completion.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low, named i_reset_n; the clock is named i_clk.
- Reset values:
  - o_ready=1, o_valid=0, o_product=0.
  - Step counter, accumulator and operand registers all 0.
  - Busy flag 0.
- States: IDLE (o_ready=1) and BUSY (o_ready=0). o_valid is a registered one-cycle pulse and is not a separate state.
- Acceptance: at rising edge E0 with i_start=1 and state IDLE:
  - Latch the multiplicand, zero-extended to 2*WIDTH bits, into the addend register.
  - Latch the multiplier into the shift register.
  - Clear the accumulator and step counter to 0; enter BUSY.
- Ignored starts: i_start=1 while BUSY has no effect. The operation in flight and its operands are unchanged.
- Iteration, edges E1..E_WIDTH (exactly WIDTH iterations):
  - If multiplier LSB=1, accumulator += addend, modulo 2^(2*WIDTH); overflow is impossible.
  - Addend shifts left by 1; multiplier shifts right by 1; step counter increments.
- Completion at edge E_WIDTH:
  - o_product is loaded with the final accumulator value.
  - o_valid=1 for the cycle E_WIDTH..E_WIDTH+1, then 0.
  - State returns to IDLE, so o_ready=1 in the same cycle o_valid=1.
- Latency:
  - o_valid is asserted exactly WIDTH clock edges after the accepting edge, independent of operand values. Zero operands get no early exit.
  - Throughput is one result per WIDTH cycles.
- Back-to-back: i_start in the cycle where o_valid=1 is accepted, because o_ready=1.
  - o_valid still drops on the next edge.
  - o_product holds the previous result until the new operation completes.
- o_product is not updated mid-operation. Intermediate accumulator values are never visible.
- Reset mid-operation: asynchronously abandons the operation; all reset values apply immediately. No o_valid pulse for the abandoned operation.
- Step counter width: $clog2(WIDTH)+1 bits, so that the value WIDTH is representable.
- Operand inputs are don't-care except on the accepting edge.

Test Plan:
- WIDTH=8, reset, then start with 3*5 → o_ready drops after E0; o_valid pulses exactly 8 edges later with o_product=15; o_ready=1 in the same cycle.
- WIDTH=8, 255*255 → o_product=0xFE01 (65025). WIDTH=32, 0xFFFFFFFF*0xFFFFFFFF → o_product=0xFFFFFFFE00000001, valid 32 edges after start.
- WIDTH=8, 0*200 and 200*0 → o_product=0, latency still 8 cycles; 1*0xAB → 0x00AB.
- WIDTH=8, start 7*9, then assert i_start with 100*100 at cycles 2 and 5 → only one o_valid pulse, with o_product=63.
- WIDTH=8, 12*12 followed by i_start with 10*11 in the o_valid cycle:
  - First pulse: o_product=144.
  - o_product holds 144 until the second pulse, which arrives 8 edges later with 110.
- WIDTH=8, start 9*9, deassert i_reset_n at cycle 4 → o_ready=1, o_valid=0, o_product=0 immediately. No o_valid ever appears for that operation; a following 2*3 yields 6.
